// File: rtl/fir_pkg.sv
// Shared definitions for the transposed-form FIR core.
// Optional feature macro: FIR_SAT_EN (adds the saturating output reducer).
package fir_pkg;

  // Working width for the rounding/saturation helpers; wide enough for any
  // supported accumulator plus one guard bit.
  localparam int SAT_W = 128;

  // Accumulator width that cannot overflow for TAPS full-scale products.
  function automatic int calc_acc_w(input int data_w, input int coef_w, input int taps);
    return data_w + coef_w + $clog2(taps);
  endfunction

  // Half-LSB constant added before the arithmetic shift (round-half-up).
  function automatic logic [SAT_W-1:0] round_const(input int frac_shift);
    logic [SAT_W-1:0] one;
    one = 1;
    if (frac_shift > 0) return one << (frac_shift - 1);
    return '0;
  endfunction

`ifdef FIR_SAT_EN
  // Clamp a sign-extended value into the signed range of out_w bits.
  function automatic logic signed [SAT_W-1:0] sat_trunc(input logic signed [SAT_W-1:0] v,
                                                        input int out_w);
    logic [SAT_W-1:0]        one;
    logic signed [SAT_W-1:0] max_v;
    logic signed [SAT_W-1:0] min_v;
    one   = 1;
    max_v = $signed((one << (out_w - 1)) - one);
    min_v = ~max_v;
    if (v > max_v) return max_v;
    if (v < min_v) return min_v;
    return v;
  endfunction
`endif

endpackage

// File: rtl/fir_transposed_core_tap.sv
// One transposed-form stage: r_out <= h*x + r_in on enable, cleared by flush.
module fir_tap_stage
  import fir_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int ACC_W  = 35
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     en,
  input  logic                     clr,
  input  logic signed [DATA_W-1:0] x,
  input  logic signed [COEF_W-1:0] h,
  input  logic signed [ACC_W-1:0]  r_in,
  output logic signed [ACC_W-1:0]  r_out
);

  localparam int PROD_W = DATA_W + COEF_W;

  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  sum_next;
  logic signed [ACC_W-1:0]  r_reg;

  assign prod     = x * h;
  assign sum_next = {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod} + r_in;
  assign r_out    = r_reg;

  // Partial-sum register; history only advances on an accepted sample.
  always_ff @(posedge clk) begin
    if (!reset_n || clr) begin
      r_reg <= '0;
    end else if (en) begin
      r_reg <= sum_next;
    end
  end

endmodule

// File: rtl/fir_transposed_core.sv
// TAPS-deep transposed-form FIR with valid/ready streams, runtime coefficient
// writes, history flush and round-half-up output conversion.
// Optional feature macro: FIR_SAT_EN (saturate instead of wrap on output).
module fir_transposed_core
  import fir_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int COEF_W     = 16,
  parameter int TAPS       = 8,
  parameter int OUT_W      = 16,
  parameter int FRAC_SHIFT = 15
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [DATA_W-1:0]         s_data,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [OUT_W-1:0]          m_data,
  input  logic                      coef_wr,
  input  logic [$clog2(TAPS)-1:0]   coef_addr,
  input  logic [COEF_W-1:0]         coef_data,
  input  logic                      flush
);

  localparam int ACC_W  = calc_acc_w(DATA_W, COEF_W, TAPS);
  localparam int PROD_W = DATA_W + COEF_W;
  localparam logic [SAT_W-1:0] RC_FULL = round_const(FRAC_SHIFT);

  logic signed [COEF_W-1:0] h_reg [TAPS];
  logic signed [ACC_W-1:0]  r_stage [TAPS-1];

  logic                     m_valid_reg;
  logic [OUT_W-1:0]         m_data_reg;
  logic                     accept;

  logic signed [PROD_W-1:0] head_prod;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W:0]    rnd_sum;
  logic signed [ACC_W:0]    shifted;
  logic signed [SAT_W-1:0]  wide;
  logic [OUT_W-1:0]         y_next;

  assign s_ready = !flush && (!m_valid_reg || m_ready);
  assign accept  = s_valid && s_ready;
  assign m_valid = m_valid_reg;
  assign m_data  = m_data_reg;

  // Coefficient bank; a write lands at the edge, so a same-cycle sample
  // still multiplies by the previous value.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < TAPS; i++) h_reg[i] <= '0;
    end else if (coef_wr && (int'(coef_addr) < TAPS)) begin
      h_reg[coef_addr] <= coef_data;
    end
  end

  // Stage k holds h[k+1]*x + r[k+1]; the last stage has no upstream sum.
  generate
    for (genvar gi = 0; gi < TAPS - 1; gi++) begin : g_tap
      logic signed [ACC_W-1:0] r_in;
      if (gi == TAPS - 2) begin : g_last
        assign r_in = '0;
      end else begin : g_mid
        assign r_in = r_stage[gi+1];
      end
      fir_tap_stage #(
        .DATA_W (DATA_W),
        .COEF_W (COEF_W),
        .ACC_W  (ACC_W)
      ) u_tap (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (accept),
        .clr     (flush),
        .x       (s_data),
        .h       (h_reg[gi+1]),
        .r_in    (r_in),
        .r_out   (r_stage[gi])
      );
    end
  endgenerate

  // Head adder, rounding and width reduction. One guard bit keeps the
  // rounding add from wrapping at the accumulator's positive limit.
  assign head_prod = $signed(s_data) * h_reg[0];
  assign acc       = {{(ACC_W - PROD_W){head_prod[PROD_W-1]}}, head_prod} + r_stage[0];
  assign rnd_sum   = {acc[ACC_W-1], acc} + $signed(RC_FULL[ACC_W:0]);
  assign shifted   = rnd_sum >>> FRAC_SHIFT;
  assign wide      = SAT_W'(shifted);

`ifdef FIR_SAT_EN
  logic signed [SAT_W-1:0] sat_v;
  assign sat_v  = sat_trunc(wide, OUT_W);
  assign y_next = sat_v[OUT_W-1:0];
`else
  assign y_next = wide[OUT_W-1:0];
`endif

  // Single-entry output register: load on accept, drop on pop or flush.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      m_valid_reg <= 1'b0;
      m_data_reg  <= '0;
    end else if (flush) begin
      m_valid_reg <= 1'b0;
    end else if (accept) begin
      m_valid_reg <= 1'b1;
      m_data_reg  <= y_next;
    end else if (m_ready) begin
      m_valid_reg <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fir_transposed_core.sv
// Directed bench: instance A (FRAC_SHIFT=0, OUT_W=32) covers the stream,
// flow-control, flush, coefficient and reset cases; instance B
// (FRAC_SHIFT=15, OUT_W=16) covers rounding and saturation/wrap.
module tb_fir_transposed_core;

  logic clk;
  logic reset_n;

  logic        a_s_valid, a_s_ready, a_m_valid, a_m_ready, a_coef_wr, a_flush;
  logic [15:0] a_s_data, a_coef_data;
  logic [31:0] a_m_data;
  logic [2:0]  a_coef_addr;

  logic        b_s_valid, b_s_ready, b_m_valid, b_m_ready, b_coef_wr, b_flush;
  logic [15:0] b_s_data, b_coef_data, b_m_data;
  logic [2:0]  b_coef_addr;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [15:0] x;
    logic [31:0] y;
  } vec_t;

  vec_t imp_tab [11];

  fir_transposed_core #(
    .DATA_W(16), .COEF_W(16), .TAPS(8), .OUT_W(32), .FRAC_SHIFT(0)
  ) dut_a (
    .clk(clk), .reset_n(reset_n),
    .s_valid(a_s_valid), .s_ready(a_s_ready), .s_data(a_s_data),
    .m_valid(a_m_valid), .m_ready(a_m_ready), .m_data(a_m_data),
    .coef_wr(a_coef_wr), .coef_addr(a_coef_addr), .coef_data(a_coef_data),
    .flush(a_flush)
  );

  fir_transposed_core #(
    .DATA_W(16), .COEF_W(16), .TAPS(8), .OUT_W(16), .FRAC_SHIFT(15)
  ) dut_b (
    .clk(clk), .reset_n(reset_n),
    .s_valid(b_s_valid), .s_ready(b_s_ready), .s_data(b_s_data),
    .m_valid(b_m_valid), .m_ready(b_m_ready), .m_data(b_m_data),
    .coef_wr(b_coef_wr), .coef_addr(b_coef_addr), .coef_data(b_coef_data),
    .flush(b_flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", nm, act);
    end
  endtask

  task automatic wr_a(input int addr, input int data);
    a_coef_wr   = 1'b1;
    a_coef_addr = 3'(addr);
    a_coef_data = 16'(data);
    step();
    a_coef_wr   = 1'b0;
  endtask

  task automatic wr_b(input int addr, input int data);
    b_coef_wr   = 1'b1;
    b_coef_addr = 3'(addr);
    b_coef_data = 16'(data);
    step();
    b_coef_wr   = 1'b0;
  endtask

  initial begin
    logic [15:0] sat_exp2;
`ifdef FIR_SAT_EN
    sat_exp2 = 16'h7FFF;
`else
    sat_exp2 = 16'hFFFC;
`endif

    for (int i = 0; i < 11; i++) begin
      imp_tab[i].x = (i == 0) ? 16'd1 : 16'd0;
      imp_tab[i].y = (i < 8) ? 32'(i + 1) : 32'd0;
    end

    a_s_valid = 0; a_s_data = 0; a_m_ready = 0; a_coef_wr = 0;
    a_coef_addr = 0; a_coef_data = 0; a_flush = 0;
    b_s_valid = 0; b_s_data = 0; b_m_ready = 0; b_coef_wr = 0;
    b_coef_addr = 0; b_coef_data = 0; b_flush = 0;
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;

    // Reset state
    chk("reset_m_valid", 64'(a_m_valid), 64'd0);
    chk("reset_m_data", 64'(a_m_data), 64'd0);
    chk("reset_s_ready", 64'(a_s_ready), 64'd1);
    chk("reset_b_m_valid", 64'(b_m_valid), 64'd0);

    // Impulse response, h = 1..8
    for (int k = 0; k < 8; k++) wr_a(k, k + 1);
    a_m_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      a_s_valid = 1'b1;
      a_s_data  = imp_tab[i].x;
      step();
      chk($sformatf("impulse_valid[%0d]", i), 64'(a_m_valid), 64'd1);
      chk($sformatf("impulse_data[%0d]", i), 64'(a_m_data), 64'(imp_tab[i].y));
    end
    a_s_valid = 1'b0;
    step();
    chk("impulse_drain_valid", 64'(a_m_valid), 64'd0);

    // Backpressure: output held, input stalled, then resumes losslessly
    a_s_valid = 1'b1;
    a_s_data  = 16'd1;
    step();
    chk("bp_first", 64'(a_m_data), 64'd1);
    a_m_ready = 1'b0;
    a_s_data  = 16'd0;
    #1;
    chk("bp_s_ready_low", 64'(a_s_ready), 64'd0);
    for (int c = 0; c < 5; c++) begin
      step();
      chk($sformatf("bp_hold_valid[%0d]", c), 64'(a_m_valid), 64'd1);
      chk($sformatf("bp_hold_data[%0d]", c), 64'(a_m_data), 64'd1);
    end
    a_m_ready = 1'b1;
    for (int k = 2; k <= 8; k++) begin
      step();
      chk($sformatf("bp_resume[%0d]", k), 64'(a_m_data), 64'(k));
    end
    a_s_valid = 1'b0;
    step();
    chk("bp_drain_valid", 64'(a_m_valid), 64'd0);

    // Flush: build history with 5s, flush, then a clean impulse
    a_s_valid = 1'b1;
    a_s_data  = 16'd5;
    step();
    chk("flush_pre0", 64'(a_m_data), 64'd5);
    step();
    chk("flush_pre1", 64'(a_m_data), 64'd15);
    step();
    chk("flush_pre2", 64'(a_m_data), 64'd30);
    a_m_ready = 1'b0;
    a_flush   = 1'b1;
    #1;
    chk("flush_s_ready", 64'(a_s_ready), 64'd0);
    step();
    chk("flush_m_valid", 64'(a_m_valid), 64'd0);
    a_flush   = 1'b0;
    a_m_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      a_s_data = imp_tab[i].x;
      step();
      chk($sformatf("post_flush[%0d]", i), 64'(a_m_data), 64'(imp_tab[i].y));
    end
    a_s_valid = 1'b0;
    step();

    // Coefficient write colliding with an accept uses the old h[0]
    for (int k = 1; k < 8; k++) wr_a(k, 0);
    a_coef_wr   = 1'b1;
    a_coef_addr = 3'd0;
    a_coef_data = 16'd2;
    a_s_valid   = 1'b1;
    a_s_data    = 16'd1;
    step();
    a_coef_wr = 1'b0;
    chk("coef_same_cycle", 64'(a_m_data), 64'd1);
    step();
    chk("coef_next", 64'(a_m_data), 64'd2);

    // Reset while an output is held
    a_m_ready = 1'b0;
    step();
    chk("rst_mid_pre_valid", 64'(a_m_valid), 64'd1);
    a_s_valid = 1'b0;
    reset_n   = 1'b0;
    step();
    reset_n = 1'b1;
    chk("rst_mid_valid", 64'(a_m_valid), 64'd0);
    chk("rst_mid_s_ready", 64'(a_s_ready), 64'd1);
    chk("rst_mid_data", 64'(a_m_data), 64'd0);
    a_m_ready = 1'b1;
    a_s_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a_s_data = imp_tab[i].x;
      step();
      chk($sformatf("rst_zero_valid[%0d]", i), 64'(a_m_valid), 64'd1);
      chk($sformatf("rst_zero_data[%0d]", i), 64'(a_m_data), 64'd0);
    end
    a_s_valid = 1'b0;

    // Rounding and saturation/wrap on instance B
    for (int k = 0; k < 8; k++) wr_b(k, 16'h7FFF);
    b_m_ready = 1'b1;
    b_s_valid = 1'b1;
    b_s_data  = 16'h7FFF;
    step();
    chk("sat_first", 64'(b_m_data), 64'h7FFE);
    step();
    chk("sat_second", 64'(b_m_data), 64'(sat_exp2));
    b_s_valid = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
